// File: rtl/decoder_n_seq.sv
// Registered N-to-2^N one-hot decoder with hold register and auto-scan sequencer.
// Define DECODER_ACTIVE_LOW_EN for one-cold (inverted) output polarity.
module decoder_n_seq #(
    parameter int SEL_W = 2,
    parameter int CNT_W = 8,
    localparam int OUT_W = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [SEL_W-1:0] sel_in,
    input  logic             load,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] dwell,
    output logic [OUT_W-1:0] out,
    output logic [SEL_W-1:0] cur_sel,
    output logic             busy,
    output logic             wrap
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_SCAN = 2'd2;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] OUT_POL = '1;
`else
    localparam logic [OUT_W-1:0] OUT_POL = '0;
`endif

    logic [1:0]       r_state, w_state_n;
    logic [SEL_W-1:0] r_sel, w_sel_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [CNT_W-1:0] r_dwell, w_dwell_n;
    logic             w_wrap_n;
    logic [OUT_W-1:0] w_out_n;
    logic [OUT_W-1:0] r_out;
    logic             r_busy;
    logic             r_wrap;

    // Priority chain: !en > stop > load > start > scan advance.
    always_comb begin
        w_state_n = r_state;
        w_sel_n   = r_sel;
        w_cnt_n   = r_cnt;
        w_dwell_n = r_dwell;
        w_wrap_n  = 1'b0;
        if (!en) begin
            w_state_n = S_IDLE;
            w_sel_n   = '0;
            w_cnt_n   = '0;
        end else if (stop) begin
            if (r_state == S_SCAN) begin
                w_state_n = S_HOLD;
                w_cnt_n   = '0;
            end
        end else if (load) begin
            w_sel_n = sel_in;
            w_cnt_n = '0;
            if (r_state == S_IDLE) begin
                w_state_n = S_HOLD;
            end
        end else if (start) begin
            w_state_n = S_SCAN;
            w_sel_n   = sel_in;
            w_dwell_n = dwell;
            w_cnt_n   = '0;
        end else if (r_state == S_SCAN) begin
            if (r_cnt == r_dwell) begin
                w_cnt_n  = '0;
                w_sel_n  = r_sel + SEL_W'(1);
                w_wrap_n = (r_sel == '1);
            end else begin
                w_cnt_n = r_cnt + CNT_W'(1);
            end
        end
    end

    // Outputs are registered from next-state values so every change lands one cycle after its cause.
    always_comb begin
        w_out_n = '0;
        if (w_state_n != S_IDLE) begin
            w_out_n = OUT_W'(1) << w_sel_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_dwell <= '0;
            r_out   <= OUT_POL;
            r_busy  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_sel   <= w_sel_n;
            r_cnt   <= w_cnt_n;
            r_dwell <= w_dwell_n;
            r_out   <= w_out_n ^ OUT_POL;
            r_busy  <= (w_state_n == S_SCAN);
            r_wrap  <= w_wrap_n;
        end
    end

    assign out     = r_out;
    assign cur_sel = r_sel;
    assign busy    = r_busy;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_decoder_n_seq.sv
// Self-checking bench for decoder_n_seq: directed steps plus randomized traffic
// compared against a countdown-based behavioural model.
module tb_decoder_n_seq;

    localparam int SEL_W = 2;
    localparam int CNT_W = 8;
    localparam int OUT_W = 4;
    localparam int NCH   = 4;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] POL = '1;
`else
    localparam logic [OUT_W-1:0] POL = '0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_HOLD = 1;
    localparam int M_SCAN = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [SEL_W-1:0] sel_in;
    logic             load;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] dwell;
    logic [OUT_W-1:0] out;
    logic [SEL_W-1:0] cur_sel;
    logic             busy;
    logic             wrap;

    int checks   = 0;
    int failures = 0;

    int m_mode;
    int m_ch;
    int m_rem;
    int m_ldw;
    bit m_wrap;

    decoder_n_seq #(.SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .sel_in (sel_in),
        .load   (load),
        .start  (start),
        .stop   (stop),
        .dwell  (dwell),
        .out    (out),
        .cur_sel(cur_sel),
        .busy   (busy),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] pat(int ch, bit idle);
        logic [OUT_W-1:0] v;
        v = idle ? '0 : OUT_W'(1 << ch);
        return v ^ POL;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        bit idle;
        idle = (m_mode == M_IDLE);
        check({tag, ".out"},     32'(out),     32'(pat(m_ch, idle)));
        check({tag, ".cur_sel"}, 32'(cur_sel), idle ? 32'd0 : 32'(m_ch));
        check({tag, ".busy"},    32'(busy),    32'(m_mode == M_SCAN));
        check({tag, ".wrap"},    32'(wrap),    32'(m_wrap));
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_ch   = 0;
        m_rem  = 0;
        m_ldw  = 0;
        m_wrap = 1'b0;
    endtask

    // Countdown view: a channel is shown for (dwell+1) cycles, m_rem counts the cycles left after this one.
    task automatic model_step();
        m_wrap = 1'b0;
        if (!en) begin
            model_reset();
        end else if (stop) begin
            if (m_mode == M_SCAN) m_mode = M_HOLD;
        end else if (load) begin
            m_ch  = int'(sel_in);
            m_rem = m_ldw;
            if (m_mode == M_IDLE) m_mode = M_HOLD;
        end else if (start) begin
            m_mode = M_SCAN;
            m_ch   = int'(sel_in);
            m_ldw  = int'(dwell);
            m_rem  = m_ldw;
        end else if (m_mode == M_SCAN) begin
            if (m_rem == 0) begin
                m_ch   = (m_ch + 1) % NCH;
                m_wrap = (m_ch == 0);
                m_rem  = m_ldw;
            end else begin
                m_rem = m_rem - 1;
            end
        end
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
        check_all(tag);
    endtask

    task automatic set_in(bit e, bit ld, bit st, bit sp, int s, int d);
        en     = e;
        load   = ld;
        start  = st;
        stop   = sp;
        sel_in = SEL_W'(s);
        dwell  = CNT_W'(d);
    endtask

    initial begin
        int wraps;
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all("rst_async");
        for (int i = 0; i < 3; i++) tick("rst_hold");
        rst_n = 1'b1;
        set_in(1, 0, 0, 0, 0, 0);
        tick("rst_release");

        set_in(1, 1, 0, 0, 2, 0);
        tick("load2");
        check("load2.lit", 32'(out), 32'(4'b0100 ^ POL));
        set_in(1, 0, 0, 0, 0, 0);

        for (int s = 0; s < 4; s++) begin
            set_in(1, 1, 0, 0, s, 0);
            tick("decode");
            check("decode.lit", 32'(out), 32'(pat(s, 1'b0)));
            set_in(1, 0, 0, 0, 0, 0);
            for (int i = 0; i < 9; i++) tick("decode_hold");
        end

        set_in(1, 0, 1, 0, 1, 2);
        tick("scan_start");
        set_in(1, 0, 0, 0, 0, 0);
        wraps = 0;
        for (int i = 0; i < 13; i++) begin
            tick("scan");
            if (wrap === 1'b1) wraps++;
        end
        check("scan.wraps", 32'(wraps), 32'd1);

        set_in(1, 0, 1, 0, 3, 5);
        tick("stop_start");
        set_in(1, 0, 0, 0, 0, 0);
        tick("stop_run");
        tick("stop_run");
        set_in(1, 0, 0, 1, 0, 0);
        tick("stop");
        set_in(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick("stop_hold");
        check("stop.lit", 32'(out), 32'(4'b1000 ^ POL));

        set_in(1, 0, 1, 0, 0, 3);
        tick("prio_start");
        set_in(1, 0, 0, 0, 0, 0);
        tick("prio_run");
        set_in(1, 1, 0, 1, 2, 0);
        tick("prio_stop_load");
        check("prio.cur_sel", 32'(cur_sel), 32'd0);
        set_in(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick("prio_after");

        set_in(1, 0, 1, 0, 1, 1);
        tick("en_start");
        set_in(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick("en_run");
        set_in(0, 0, 0, 0, 0, 0);
        tick("en_low");
        check("en_low.lit", 32'(out), 32'(pat(0, 1'b1)));
        set_in(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick("en_idle");

        set_in(1, 0, 1, 0, 2, 1);
        tick("rstmid_start");
        set_in(1, 0, 0, 0, 0, 0);
        tick("rstmid_run");
        tick("rstmid_run");
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("rst_mid");
        tick("rst_mid_hold");
        tick("rst_mid_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick("rst_mid_idle");

        set_in(1, 0, 1, 0, 0, 255);
        tick("dwmax_start");
        set_in(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 260; i++) tick("dwmax");

        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 19) != 0,
                   $urandom_range(0, 7) == 0,
                   $urandom_range(0, 7) == 0,
                   $urandom_range(0, 7) == 0,
                   int'($urandom_range(0, NCH - 1)),
                   int'($urandom_range(0, 3)));
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
